// File: rtl/shift_tx_if.sv
// shift_tx_if: word-load handshake and serial output bundle for shift_tx.
// Latency: none, this is a plain signal grouping with no storage.
// Backpressure: the producer presents d/load and the word is taken only on an edge where ready=1.
//
// Signals:
//   d           producer -> tx   WIDTH-bit word to transmit
//   load        producer -> tx   word-valid strobe
//   ready       tx -> producer   one-entry holding buffer is empty
//   sdo         tx -> link       serial data, MSB first, 0 when not valid
//   sdo_valid   tx -> link       sdo carries a frame bit this cycle
//   frame_start tx -> link       high on the MSB of each frame
//   busy        tx -> link       engine not idle
interface shift_tx_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] d;
  logic             load;
  logic             ready;
  logic             sdo;
  logic             sdo_valid;
  logic             frame_start;
  logic             busy;

  // master: the word producer / link observer side
  modport master (
    output d, load,
    input  ready, sdo, sdo_valid, frame_start, busy
  );

  // slave: the transmitter itself
  modport slave (
    input  d, load,
    output ready, sdo, sdo_valid, frame_start, busy
  );
endinterface

// File: rtl/shift_tx.sv
// shift_tx: parallel-in, serial-out transmitter with a one-entry holding buffer, MSB first.
// Latency: word accepted at edge E0, MSB on sdo after E1; a frame is WIDTH cycles (WIDTH+1 with parity).
// Backpressure: ready=!hold_full; a load while ready=0 is ignored and the held word is kept.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   tx     shift_tx_if.slave (d, load, ready, sdo, sdo_valid, frame_start, busy)
// Build option:
//   SHIFT_TX_PARITY_EN  appends one even-parity bit after the data bits of every frame.
module shift_tx #(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  shift_tx_if.slave   tx
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             frame_start_q, frame_start_d;
`ifdef SHIFT_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  logic last;
  logic accept;
  logic drain;

  // Next-state logic
  always_comb begin
    // "last" = the frame's final bit is on sdo this cycle
`ifdef SHIFT_TX_PARITY_EN
    last = (state_q == S_PARITY);
`else
    last = (state_q == S_SHIFT) && (cnt_q == '0);
`endif
    accept = tx.load && !hold_full_q;
    drain  = hold_full_q && ((state_q == S_IDLE) || last);

    state_d       = state_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    frame_start_d = frame_start_q;
`ifdef SHIFT_TX_PARITY_EN
    par_d         = par_q;
`endif

    // accept and drain are mutually exclusive: one needs the buffer empty, the other full
    if (accept) begin
      hold_d      = tx.d;
      hold_full_d = 1'b1;
    end

    case (state_q)
      S_SHIFT: begin
        frame_start_d = 1'b0;
`ifdef SHIFT_TX_PARITY_EN
        par_d = par_q ^ shreg_q[WIDTH-1];
`endif
        if (cnt_q == '0) begin
`ifdef SHIFT_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_IDLE;
`endif
        end else begin
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q - CW'(1);
        end
      end
`ifdef SHIFT_TX_PARITY_EN
      S_PARITY: begin
        frame_start_d = 1'b0;
        state_d       = S_IDLE;
      end
`endif
      default: begin
        frame_start_d = 1'b0;
        state_d       = S_IDLE;
      end
    endcase

    // Drain overrides the frame-end transition so a queued word follows with no gap
    if (drain) begin
      shreg_d       = hold_q;
      cnt_d         = CW'(WIDTH - 1);
      hold_full_d   = 1'b0;
      state_d       = S_SHIFT;
      frame_start_d = 1'b1;
`ifdef SHIFT_TX_PARITY_EN
      par_d         = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      shreg_q       <= '0;
      cnt_q         <= '0;
      frame_start_q <= 1'b0;
`ifdef SHIFT_TX_PARITY_EN
      par_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      frame_start_q <= frame_start_d;
`ifdef SHIFT_TX_PARITY_EN
      par_q         <= par_d;
`endif
    end
  end

  // Output decode from registered state; reset drops sdo/sdo_valid without waiting for a clock
  always_comb begin
    tx.sdo       = 1'b0;
    tx.sdo_valid = 1'b0;
    case (state_q)
      S_SHIFT: begin
        tx.sdo       = shreg_q[WIDTH-1];
        tx.sdo_valid = 1'b1;
      end
`ifdef SHIFT_TX_PARITY_EN
      S_PARITY: begin
        tx.sdo       = par_q;
        tx.sdo_valid = 1'b1;
      end
`endif
      default: begin
        tx.sdo       = 1'b0;
        tx.sdo_valid = 1'b0;
      end
    endcase
  end

  assign tx.ready       = !hold_full_q;
  assign tx.frame_start = frame_start_q;
  assign tx.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_shift_tx.sv
// tb_shift_tx: directed and random stimulus for shift_tx against a queue-based stream model.
// Latency: the model predicts every cycle's outputs; frames are checked bit by bit.
// Backpressure: loads are driven regardless of ready; the model discards loads that arrive while the buffer is full.
module tb_shift_tx;
  localparam int WIDTH = 4;

`ifdef SHIFT_TX_PARITY_EN
  localparam int          T1_N = 5;
  localparam logic [15:0] T1_S = 16'b11011;
  localparam int          T2_N = 10;
  localparam logic [15:0] T2_S = 16'b1101100011;
  localparam int          T3_N = 10;
  localparam logic [15:0] T3_S = 16'b1101100110;
`else
  localparam int          T1_N = 4;
  localparam logic [15:0] T1_S = 16'b1101;
  localparam int          T2_N = 8;
  localparam logic [15:0] T2_S = 16'b11010001;
  localparam int          T3_N = 8;
  localparam logic [15:0] T3_S = 16'b11010011;
`endif

  logic clk = 1'b0;
  logic reset;

  shift_tx_if #(.WIDTH(WIDTH)) tx ();
  shift_tx #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .tx(tx));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the serial stream still to appear on the wire, plus the holding buffer
  typedef struct packed {
    logic b;
    logic st;
  } obit_t;
  obit_t            exp_q[$];
  logic             m_held;
  logic [WIDTH-1:0] m_word;

  // Bits observed on the wire during a directed test
  logic [15:0] seq;
  int          nbits;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_held = 1'b0;
    m_word = '0;
  endtask

  task automatic push_frame(input logic [WIDTH-1:0] w);
    obit_t o;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      o.b  = w[i];
      o.st = (i == WIDTH - 1);
      exp_q.push_back(o);
    end
`ifdef SHIFT_TX_PARITY_EN
    o.b  = ^w;
    o.st = 1'b0;
    exp_q.push_back(o);
`endif
  endtask

  // One clock edge of the model: the held word joins the stream once at most one bit remains
  task automatic model_edge(input logic ld, input logic [WIDTH-1:0] dv);
    logic do_accept, do_drain;
    do_accept = ld && !m_held;
    do_drain  = m_held && (exp_q.size() <= 1);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (do_drain) begin
      push_frame(m_word);
      m_held = 1'b0;
    end
    if (do_accept) begin
      m_held = 1'b1;
      m_word = dv;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic ev, es, ef;
    ev = (exp_q.size() > 0);
    es = ev ? exp_q[0].b : 1'b0;
    ef = ev ? exp_q[0].st : 1'b0;
    check({tag, ".sdo_valid"},   32'(tx.sdo_valid),   32'(ev));
    check({tag, ".sdo"},         32'(tx.sdo),         32'(es));
    check({tag, ".frame_start"}, 32'(tx.frame_start), 32'(ef));
    check({tag, ".busy"},        32'(tx.busy),        32'(ev));
    check({tag, ".ready"},       32'(tx.ready),       32'(!m_held));
  endtask

  // Drive inputs after a falling edge, clock once, then compare away from the rising edge
  task automatic step(input string tag, input logic ld, input logic [WIDTH-1:0] dv);
    tx.load = ld;
    tx.d    = dv;
    @(posedge clk);
    model_edge(ld, dv);
    @(negedge clk);
    check_outputs(tag);
    if (tx.sdo_valid === 1'b1) begin
      seq = {seq[14:0], tx.sdo};
      nbits++;
    end
  endtask

  initial begin
    reset   = 1'b1;
    tx.load = 1'b0;
    tx.d    = '0;
    model_reset();
    seq   = '0;
    nbits = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst.sdo",         32'(tx.sdo),         32'd0);
    check("rst.sdo_valid",   32'(tx.sdo_valid),   32'd0);
    check("rst.frame_start", 32'(tx.frame_start), 32'd0);
    check("rst.busy",        32'(tx.busy),        32'd0);
    check("rst.ready",       32'(tx.ready),       32'd1);
    reset = 1'b0;

    // Single frame from idle
    seq = '0; nbits = 0;
    step("t1", 1'b1, 4'b1101);
    for (int i = 0; i < 6; i++) step("t1", 1'b0, 4'b0000);
    check("t1.nbits", 32'(nbits), 32'(T1_N));
    check("t1.seq",   32'(seq),   32'(T1_S));

    // Second word loaded while the second bit of the first is on the wire
    seq = '0; nbits = 0;
    step("t2", 1'b1, 4'b1101);
    step("t2", 1'b0, 4'b0000);
    step("t2", 1'b0, 4'b0000);
    step("t2", 1'b1, 4'b0001);
    for (int i = 0; i < 10; i++) step("t2", 1'b0, 4'b0000);
    check("t2.nbits", 32'(nbits), 32'(T2_N));
    check("t2.seq",   32'(seq),   32'(T2_S));

    // Load while the buffer is full is ignored
    seq = '0; nbits = 0;
    step("t3", 1'b1, 4'b1101);
    step("t3", 1'b0, 4'b0000);
    step("t3", 1'b1, 4'b0011);
    step("t3", 1'b1, 4'b1111);
    step("t3", 1'b1, 4'b1111);
    for (int i = 0; i < 10; i++) step("t3", 1'b0, 4'b0000);
    check("t3.nbits", 32'(nbits), 32'(T3_N));
    check("t3.seq",   32'(seq),   32'(T3_S));

    // Reset during bit 2 with a word also held
    step("t4", 1'b1, 4'b1101);
    step("t4", 1'b0, 4'b0000);
    step("t4", 1'b1, 4'b0110);
    reset = 1'b1;
    #1;
    check("t4.sdo_valid", 32'(tx.sdo_valid), 32'd0);
    check("t4.sdo",       32'(tx.sdo),       32'd0);
    check("t4.busy",      32'(tx.busy),      32'd0);
    check("t4.ready",     32'(tx.ready),     32'd1);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    check_outputs("t4.rel");
    seq = '0; nbits = 0;
    for (int i = 0; i < 8; i++) step("t4", 1'b0, 4'b0000);
    check("t4.nbits", 32'(nbits), 32'd0);

    // Random loads and words, including back-to-back pressure
    for (int i = 0; i < 400; i++) begin
      step("rnd", ($urandom_range(0, 99) < 45), WIDTH'($urandom));
    end
    for (int i = 0; i < 12; i++) step("drain", 1'b0, 4'b0000);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_tx.md
# shift_tx

Parallel-in, serial-out transmitter: the sending end of the serial link whose receiving end is the serial-in shift register. It accepts a WIDTH-bit word through a load/ready handshake. It holds the word in a one-entry buffer, then shifts it out MSB-first, one bit per clock, with framing strobes. The buffer lets the next word be accepted while the current one shifts, so consecutive frames leave no idle cycle between them.

## Interface
- WIDTH, 4, data word width; legal range 2..32.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- d  input  WIDTH  parallel word to transmit.
- load  input  1  word-valid strobe; the word is accepted on a rising edge when load && ready.
- ready  output  1  holding buffer empty, so a word can be accepted; equals !hold_full.
- sdo  output  1  serial data out; forced to 0 when sdo_valid=0.
- sdo_valid  output  1  sdo carries a frame bit this cycle.
- frame_start  output  1  high on the first (MSB) bit of each frame.
- busy  output  1  engine is in any state other than IDLE.

## Operation
- Storage:
  - hold register (WIDTH) plus hold_full flag.
  - shift register shreg (WIDTH), holds the word being sent.
  - bit counter cnt, $clog2(WIDTH) bits wide.
- States:
  - IDLE: sdo_valid=0.
  - SHIFT: sdo=shreg[WIDTH-1], sdo_valid=1.
  - PARITY: exists only with the macro; sdo=par, sdo_valid=1.
- Accept rule: on an edge with load && ready, hold<=d and hold_full<=1. A load while ready=0 is ignored; the held word is not overwritten.
- Drain rule, evaluated on every edge, with "last" meaning the frame's final bit is on sdo:
  - Condition: hold_full && (IDLE || last).
  - Action: shreg<=hold, cnt<=WIDTH-1, hold_full<=0, state<=SHIFT, frame_start<=1.
- SHIFT step, when not last: shreg<=shreg<<1, cnt<=cnt-1, frame_start<=0.
- Frame end without the macro: in SHIFT with cnt==0, go to SHIFT for the next word if the drain rule fires, otherwise to IDLE.
- A load at the same edge as a drain is not accepted, because ready was 0. The buffer is refilled from the following cycle.
- outputs are registered state; sdo and sdo_valid are decoded from state and shreg.

## Timing
- Reset values, asserted asynchronously:
  - state=IDLE, hold_full=0, shreg=0, cnt=0.
  - sdo=0, sdo_valid=0, frame_start=0, busy=0, ready=1.
- Latency from idle: load sampled at edge E0 (word enters hold); first bit appears after edge E1; frame spans E1..E1+WIDTH.
- Frame length: WIDTH cycles, or WIDTH+1 with parity.
- Throughput: one bit per cycle, sustained when each new word is loaded within WIDTH-1 cycles of the previous drain.
- Reset mid-frame:
  - sdo_valid and sdo drop to 0 immediately.
  - The partial frame and any held word are discarded.
  - After reset deasserts, ready=1 on the first cycle and no residual bits are sent.
- Simultaneous last bit and full hold: the next frame's MSB follows on the very next cycle, with frame_start=1.

## Configuration
- SHIFT_TX_PARITY_EN defined:
  - A running even-parity register par accumulates XOR of the transmitted data bits.
  - After cnt==0 in SHIFT, go to PARITY for one cycle with sdo=par.
  - "last" is the PARITY state; drain into the next frame happens from PARITY.
- Undefined: no PARITY state, no par register; frame is exactly WIDTH bits.

## Test plan
- WIDTH=4. Release reset, then pulse load with d=4'b1101 → sdo 1,1,0,1 on 4 consecutive cycles; sdo_valid high for those 4; frame_start only on the first; then IDLE, sdo=0, busy=0.
- Load 1101, then load 0001 during the second bit → 8 contiguous valid cycles 1,1,0,1,0,0,0,1; frame_start on cycles 1 and 5; ready low from the second accept until the second drain.
- With hold full, drive load and d=4'b1111 → ignored (ready=0); the queued word is transmitted unchanged.
- Assert reset during bit 2 of 1101 → sdo_valid=0 and busy=0 immediately; after release ready=1 and nothing is sent until a new load.
- SHIFT_TX_PARITY_EN, d=4'b1101 → 1,1,0,1,1 (5 valid cycles); d=4'b1001 → 1,0,0,1,0.
- WIDTH=8, d=8'hA5 → 1,0,1,0,0,1,0,1; busy high for exactly 8 cycles.
